// File: rtl/rf_commit_arbiter.sv
// rf_commit_arbiter
//   Sits between the dual-lane ROB commit stage and the single register-file
//   write port. Committed results are buffered in program order (lane 0 older
//   than lane 1) and retired one per cycle. A flush request drains all older
//   committed writes, then pulses rf_flush_out for one cycle.
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   rdy_in                  global ready; 0 freezes all state
//   c0_*/c1_*               commit lanes (valid/ready handshake, rd, value, tag)
//   flush_req_in            flush request pulse from the ROB
//   flush_busy_out          flush sequence in progress
//   rf_valid_out, rf_rd_out, rf_value_out, rf_tag_out   RF write port
//   rf_flush_out            RF flush strobe
//   count_out               occupied buffer entries
module rf_commit_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROB_W = 5,
  parameter int unsigned REG_W = 5
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,

  input  logic                       c0_valid_in,
  output logic                       c0_ready_out,
  input  logic [REG_W-1:0]           c0_rd_in,
  input  logic [31:0]                c0_value_in,
  input  logic [ROB_W-1:0]           c0_tag_in,

  input  logic                       c1_valid_in,
  output logic                       c1_ready_out,
  input  logic [REG_W-1:0]           c1_rd_in,
  input  logic [31:0]                c1_value_in,
  input  logic [ROB_W-1:0]           c1_tag_in,

  input  logic                       flush_req_in,
  output logic                       flush_busy_out,

  output logic                       rf_valid_out,
  output logic [REG_W-1:0]           rf_rd_out,
  output logic [31:0]                rf_value_out,
  output logic [ROB_W-1:0]           rf_tag_out,
  output logic                       rf_flush_out,

  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t state, state_next;
  logic   flush_next;

  logic [REG_W-1:0] mem_rd    [DEPTH];
  logic [31:0]      mem_value [DEPTH];
  logic [ROB_W-1:0] mem_tag   [DEPTH];

  logic [PTR_W-1:0] head, tail, tail_c1;
  logic [CNT_W-1:0] count, count_next, free_slots;

  logic run_ok;
  logic push0, push1, pop;

  assign count_out = count;

  // Readies come only from registered count/state: no credit is given for a
  // dequeue happening in the same cycle.
  always_comb begin
    free_slots   = CNT_W'(DEPTH) - count;
    run_ok       = rst_n_in & rdy_in & (state == S_RUN);
    c0_ready_out = run_ok & (free_slots >= CNT_W'(1));
    c1_ready_out = run_ok & (free_slots >= CNT_W'(2));
  end

  // rd==0 commits complete the handshake but never occupy a slot.
  always_comb begin
    push0      = c0_valid_in & c0_ready_out & (c0_rd_in != '0);
    push1      = c1_valid_in & c1_ready_out & (c1_rd_in != '0);
    pop        = rdy_in & (count != '0);
    tail_c1    = push0 ? tail + PTR_W'(1) : tail;
    count_next = count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  end

  // Storage array carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk_in) begin
    if (push0) begin
      mem_rd[tail]    <= c0_rd_in;
      mem_value[tail] <= c0_value_in;
      mem_tag[tail]   <= c0_tag_in;
    end
    if (push1) begin
      mem_rd[tail_c1]    <= c1_rd_in;
      mem_value[tail_c1] <= c1_value_in;
      mem_tag[tail_c1]   <= c1_tag_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      tail  <= tail + PTR_W'(push0) + PTR_W'(push1);
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // RF write registers: the payload holds while idle or frozen so the RF can
  // still apply a write held across rdy_in=0.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rf_valid_out <= 1'b0;
      rf_rd_out    <= '0;
      rf_value_out <= '0;
      rf_tag_out   <= '0;
    end else if (rdy_in) begin
      rf_valid_out <= pop;
      if (pop) begin
        rf_rd_out    <= mem_rd[head];
        rf_value_out <= mem_value[head];
        rf_tag_out   <= mem_tag[head];
      end
    end
  end

  // DRAIN waits until the last write has left the rf_* register, so the
  // flush strobe can never coincide with a write strobe.
  always_comb begin
    state_next = state;
    flush_next = 1'b0;
    case (state)
      S_RUN: begin
        if (flush_req_in) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((count == '0) && !rf_valid_out) begin
          state_next = S_FLUSH;
          flush_next = 1'b1;
        end
      end
      S_FLUSH: begin
        state_next = S_RUN;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= S_RUN;
      rf_flush_out   <= 1'b0;
      flush_busy_out <= 1'b0;
    end else if (rdy_in) begin
      state          <= state_next;
      rf_flush_out   <= flush_next;
      flush_busy_out <= (state_next != S_RUN);
    end
  end

endmodule

// File: tb/tb_rf_commit_arbiter.sv
// tb_rf_commit_arbiter
//   Randomized bench for rf_commit_arbiter with a queue-based reference model
//   of the commit buffer and the flush sequence.
module tb_rf_commit_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ROB_W = 5;
  localparam int unsigned REG_W = 5;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             rdy_in;
  logic             c0_valid_in, c1_valid_in;
  logic             c0_ready_out, c1_ready_out;
  logic [REG_W-1:0] c0_rd_in, c1_rd_in;
  logic [31:0]      c0_value_in, c1_value_in;
  logic [ROB_W-1:0] c0_tag_in, c1_tag_in;
  logic             flush_req_in;
  logic             flush_busy_out;
  logic             rf_valid_out;
  logic [REG_W-1:0] rf_rd_out;
  logic [31:0]      rf_value_out;
  logic [ROB_W-1:0] rf_tag_out;
  logic             rf_flush_out;
  logic [$clog2(DEPTH):0] count_out;

  rf_commit_arbiter #(.DEPTH(DEPTH), .ROB_W(ROB_W), .REG_W(REG_W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .c0_valid_in(c0_valid_in), .c0_ready_out(c0_ready_out), .c0_rd_in(c0_rd_in),
    .c0_value_in(c0_value_in), .c0_tag_in(c0_tag_in),
    .c1_valid_in(c1_valid_in), .c1_ready_out(c1_ready_out), .c1_rd_in(c1_rd_in),
    .c1_value_in(c1_value_in), .c1_tag_in(c1_tag_in),
    .flush_req_in(flush_req_in), .flush_busy_out(flush_busy_out),
    .rf_valid_out(rf_valid_out), .rf_rd_out(rf_rd_out), .rf_value_out(rf_value_out),
    .rf_tag_out(rf_tag_out), .rf_flush_out(rf_flush_out), .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [REG_W-1:0] rd;
    logic [31:0]      val;
    logic [ROB_W-1:0] tag;
  } ent_t;

  // Reference model: pending writes in program order plus expected outputs.
  ent_t             q[$];
  bit               m_drain, m_flush;
  bit               e_valid, e_flush;
  logic [REG_W-1:0] e_rd;
  logic [31:0]      e_val;
  logic [ROB_W-1:0] e_tag;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    q.delete();
    m_drain = 0; m_flush = 0;
    e_valid = 0; e_flush = 0;
    e_rd = '0; e_val = '0; e_tag = '0;
  endtask

  task automatic check_outputs(input bit exp_r0, input bit exp_r1);
    check("c0_ready",   {31'd0, c0_ready_out},   {31'd0, exp_r0});
    check("c1_ready",   {31'd0, c1_ready_out},   {31'd0, exp_r1});
    check("count",      32'(count_out),          32'(q.size()));
    check("rf_valid",   {31'd0, rf_valid_out},   {31'd0, e_valid});
    check("rf_rd",      32'(rf_rd_out),          32'(e_rd));
    check("rf_value",   rf_value_out,            e_val);
    check("rf_tag",     32'(rf_tag_out),         32'(e_tag));
    check("rf_flush",   {31'd0, rf_flush_out},   {31'd0, e_flush});
    check("flush_busy", {31'd0, flush_busy_out}, {31'd0, (m_drain | m_flush)});
  endtask

  // One cycle: drive at negedge, check outputs of the previous edge, then
  // advance the model to what the next posedge should produce.
  task automatic step(input bit rdy, input bit v0, input logic [REG_W-1:0] r0,
                      input logic [31:0] d0, input logic [ROB_W-1:0] t0,
                      input bit v1, input logic [REG_W-1:0] r1,
                      input logic [31:0] d1, input logic [ROB_W-1:0] t1,
                      input bit fr);
    bit   run, er0, er1, had, old_valid;
    int   old_size, free;
    ent_t h;
    @(negedge clk_in);
    rdy_in = rdy;
    c0_valid_in = v0; c0_rd_in = r0; c0_value_in = d0; c0_tag_in = t0;
    c1_valid_in = v1; c1_rd_in = r1; c1_value_in = d1; c1_tag_in = t1;
    flush_req_in = fr;
    #1;
    run  = rdy && !m_drain && !m_flush;
    free = int'(DEPTH) - q.size();
    er0  = run && free >= 1;
    er1  = run && free >= 2;
    check_outputs(er0, er1);
    if (rdy) begin
      old_size  = q.size();
      old_valid = e_valid;
      had = old_size > 0;
      if (had) h = q.pop_front();
      if (v0 && er0 && r0 != 0) q.push_back('{r0, d0, t0});
      if (v1 && er1 && r1 != 0) q.push_back('{r1, d1, t1});
      e_valid = had;
      if (had) begin e_rd = h.rd; e_val = h.val; e_tag = h.tag; end
      e_flush = 0;
      if (m_flush) m_flush = 0;
      else if (m_drain) begin
        if (old_size == 0 && !old_valid) begin
          m_drain = 0; m_flush = 1; e_flush = 1;
        end
      end else if (fr) m_drain = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, '0, '0, 0, '0, '0, '0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk_in);
    c0_valid_in = 0; c1_valid_in = 0; flush_req_in = 0;
    #2 rst_n_in = 0;
    #1;
    model_clear();
    check_outputs(0, 0);
    @(negedge clk_in);
    rst_n_in = 1;
  endtask

  function automatic logic [REG_W-1:0] rand_rd();
    if ($urandom_range(0, 5) == 0) return '0;
    return REG_W'($urandom_range(1, (1 << REG_W) - 1));
  endfunction

  initial begin
    rst_n_in = 0; rdy_in = 0; flush_req_in = 0;
    c0_valid_in = 0; c0_rd_in = '0; c0_value_in = '0; c0_tag_in = '0;
    c1_valid_in = 0; c1_rd_in = '0; c1_value_in = '0; c1_tag_in = '0;
    model_clear();
    repeat (2) @(negedge clk_in);
    #1 check_outputs(0, 0);
    rst_n_in = 1;

    // Dual commit, then a zero-rd lane 0 paired with a real lane 1.
    step(1, 1, 5'd5, 32'h11, 5'd3, 1, 5'd6, 32'h22, 5'd4, 0);
    idle(3);
    step(1, 1, 5'd0, 32'h99, 5'd1, 1, 5'd7, 32'h77, 5'd2, 0);
    idle(3);
    // Saturate the buffer, then flush with entries queued, freezing mid-drain.
    for (int i = 0; i < 4; i++)
      step(1, 1, 5'(i + 1), 32'(i), 5'(i), 1, 5'(i + 9), 32'(i + 100), 5'(i + 8), 0);
    step(1, 0, '0, '0, '0, 0, '0, '0, '0, 1);
    step(1, 0, '0, '0, '0, 0, '0, '0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 5'd3, 32'h5, 5'd1, 1, 5'd4, 32'h6, 5'd2, 1);
    idle(10);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 1500 || cyc == 3100) async_reset();
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 7, rand_rd(), $urandom, ROB_W'($urandom),
           $urandom_range(0, 9) < 7, rand_rd(), $urandom, ROB_W'($urandom),
           $urandom_range(0, 39) == 0);
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
